sme_memory_arbiter: RTL and testbench

Arbitrates the shared Sensor Manager memory between two requesters: the sensor engine (requester 0) and the host/AHB bridge (requester 1). Drives the memory mux Select line and gates memory enables during ownership changes. Uses a request/grant handshake with a programmable turnaround gap. Sits directly upstream of the memory mux, one instance per shared memory.

---
 rtl/sme_mem_arb_pkg.sv | 56 +++++
 rtl/sme_memory_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_sme_memory_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// sme_mem_arb_pkg
// Shared definitions for the Sensor Manager memory arbiter:
//   - FSM state encoding (IDLE, SWITCH, GRANT0, GRANT1)
//   - owner constants (engine = requester 0, host = requester 1)
//   - counter width constants (turnaround and hold counters)
//   - helper functions for winner selection and owner -> grant-state mapping
// Optional feature macro referenced by users of this package: SME_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package sme_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SWITCH = 2'b01,
        ST_GRANT0 = 2'b10,
        ST_GRANT1 = 2'b11
    } arb_state_t;

    localparam logic OWNER_ENGINE = 1'b0;
    localparam logic OWNER_HOST   = 1'b1;

    localparam int unsigned TURN_CNT_W = 4;
    localparam int unsigned HOLD_CNT_W = 10;

    // Winner of an arbitration round. On a tie, round-robin picks the
    // requester that did not own the memory last; fixed priority picks the
    // engine.
    function automatic logic pick_winner(
        input logic req0,
        input logic req1,
        input logic last_owner,
        input logic round_robin
    );
        logic winner;
        if (req0 && req1) begin
            winner = round_robin ? ~last_owner : OWNER_ENGINE;
        end else if (req1) begin
            winner = OWNER_HOST;
        end else begin
            winner = OWNER_ENGINE;
        end
        return winner;
    endfunction

    // Grant state that corresponds to a given owner index.
    function automatic arb_state_t grant_state(input logic owner);
        arb_state_t st;
        if (owner == OWNER_HOST) begin
            st = ST_GRANT1;
        end else begin
            st = ST_GRANT0;
        end
        return st;
    endfunction

endpackage

// File: rtl/sme_memory_arbiter.sv
// -----------------------------------------------------------------------------
// sme_memory_arbiter
// Arbitrates one shared Sensor Manager memory between the sensor engine
// (requester 0) and the host/AHB bridge (requester 1). Drives the memory mux
// select and gates memory enables while ownership changes hands, inserting
// TURNAROUND_CYCLES dead cycles after every Select change.
//
// Parameters:
//   TURNAROUND_CYCLES  dead cycles between Select change and Grant (0..15)
//   PRIORITY_RR        1 = round-robin on ties, 0 = requester 0 always wins
//   MAX_HOLD           hold limit while the other side waits (1..1023),
//                      only effective when SME_ARB_TIMEOUT_EN is defined
//
// Ports:
//   ClockIn          clock
//   ResetInN         asynchronous active-low reset
//   Req0 / Req1      requests, held high for the whole ownership period
//   Grant0 / Grant1  ownership indications (never both high)
//   Select           mux select, 0 = requester 0 path, 1 = requester 1 path
//   MemAccessEnable  memory enable gate, equals Grant0 | Grant1
//   Busy             arbiter not idle
//   TimeoutEvent     one-cycle pulse on forced release (0 unless
//                    SME_ARB_TIMEOUT_EN is defined)
//
// Optional feature macro: SME_ARB_TIMEOUT_EN (hold-timeout preemption).
// All outputs are registered and derived from the next state.
// -----------------------------------------------------------------------------
module sme_memory_arbiter
    import sme_mem_arb_pkg::*;
#(
    parameter int unsigned TURNAROUND_CYCLES = 1,
    parameter bit          PRIORITY_RR       = 1'b1,
    parameter int unsigned MAX_HOLD          = 64
) (
    input  logic ClockIn,
    input  logic ResetInN,
    input  logic Req0,
    input  logic Req1,
    output logic Grant0,
    output logic Grant1,
    output logic Select,
    output logic MemAccessEnable,
    output logic Busy,
    output logic TimeoutEvent
);

    // Elaboration-time guard on the legal parameter ranges.
    if ((TURNAROUND_CYCLES > 32'd15) || (MAX_HOLD < 32'd1) || (MAX_HOLD > 32'd1023)) begin : g_bad_param
        $error("sme_memory_arbiter: TURNAROUND_CYCLES or MAX_HOLD out of range");
    end

    localparam bit TURN_ZERO = (TURNAROUND_CYCLES == 32'd0);
    // The counter is loaded with N-1 on entry to SWITCH so that the grant
    // lands exactly N edges after the Select change.
    localparam logic [TURN_CNT_W-1:0] TURN_INIT =
        TURN_ZERO ? {TURN_CNT_W{1'b0}} : TURN_CNT_W'(TURNAROUND_CYCLES - 32'd1);

    arb_state_t             r_state;
    logic                   r_select;
    logic                   r_last_owner;
    logic [TURN_CNT_W-1:0]  r_tcnt;
    logic                   r_grant0;
    logic                   r_grant1;
    logic                   r_mae;
    logic                   r_busy;

    arb_state_t             w_state_nx;
    logic                   w_select_nx;
    logic                   w_last_nx;
    logic [TURN_CNT_W-1:0]  w_tcnt_nx;
    logic                   w_go_en;
    logic                   w_go_tgt;
    logic                   w_own_req;
    logic                   w_oth_req;

`ifdef SME_ARB_TIMEOUT_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 32'd1);
    logic [HOLD_CNT_W-1:0]  r_hold;
    logic [HOLD_CNT_W-1:0]  w_hold_nx;
    logic                   r_timeout;
    logic                   w_timeout_nx;
`endif

    // Select always points at the current owner or the pending winner, so the
    // request seen through Select is the one that matters in SWITCH/GRANTn.
    assign w_own_req = r_select ? Req1 : Req0;
    assign w_oth_req = r_select ? Req0 : Req1;

    // Next-state logic: decides ownership moves, turnaround countdown and
    // (optionally) hold-timeout preemption.
    always_comb begin
        w_state_nx  = r_state;
        w_select_nx = r_select;
        w_last_nx   = r_last_owner;
        w_tcnt_nx   = r_tcnt;
        w_go_en     = 1'b0;
        w_go_tgt    = r_select;
`ifdef SME_ARB_TIMEOUT_EN
        w_hold_nx    = r_hold;
        w_timeout_nx = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (Req0 || Req1) begin
                    w_go_en  = 1'b1;
                    w_go_tgt = pick_winner(Req0, Req1, r_last_owner, PRIORITY_RR);
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                if (!w_own_req) begin
                    // Pending winner gave up: no grant is issued.
                    if (w_oth_req) begin
                        w_go_en  = 1'b1;
                        w_go_tgt = ~r_select;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else if (r_tcnt == {TURN_CNT_W{1'b0}}) begin
                    w_state_nx = grant_state(r_select);
                    w_last_nx  = r_select;
                end else begin
                    w_tcnt_nx = r_tcnt - {{(TURN_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!w_own_req) begin
                    if (w_oth_req) begin
                        w_go_en  = 1'b1;
                        w_go_tgt = ~r_select;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
`ifdef SME_ARB_TIMEOUT_EN
                    if (w_oth_req) begin
                        if (r_hold == HOLD_LIMIT) begin
                            w_go_en      = 1'b1;
                            w_go_tgt     = ~r_select;
                            w_timeout_nx = 1'b1;
                        end else begin
                            w_hold_nx = r_hold + {{(HOLD_CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        w_hold_nx = r_hold;
                    end
`else
                    w_state_nx = r_state;
`endif
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        // Common ownership move: grant immediately when the mux already points
        // at the winner (or no turnaround is configured), else open a gap.
        if (w_go_en) begin
            w_select_nx = w_go_tgt;
            if ((w_go_tgt == r_select) || TURN_ZERO) begin
                w_state_nx = grant_state(w_go_tgt);
                w_last_nx  = w_go_tgt;
            end else begin
                w_state_nx = ST_SWITCH;
                w_tcnt_nx  = TURN_INIT;
            end
`ifdef SME_ARB_TIMEOUT_EN
            w_hold_nx = {HOLD_CNT_W{1'b0}};
`endif
        end else begin
            w_go_tgt = r_select;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge ClockIn or negedge ResetInN) begin
        if (!ResetInN) begin
            r_state      <= ST_IDLE;
            r_select     <= OWNER_ENGINE;
            r_last_owner <= OWNER_HOST;
            r_tcnt       <= {TURN_CNT_W{1'b0}};
            r_grant0     <= 1'b0;
            r_grant1     <= 1'b0;
            r_mae        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_select     <= w_select_nx;
            r_last_owner <= w_last_nx;
            r_tcnt       <= w_tcnt_nx;
            r_grant0     <= (w_state_nx == ST_GRANT0);
            r_grant1     <= (w_state_nx == ST_GRANT1);
            r_mae        <= (w_state_nx == ST_GRANT0) || (w_state_nx == ST_GRANT1);
            r_busy       <= (w_state_nx != ST_IDLE);
        end
    end

`ifdef SME_ARB_TIMEOUT_EN
    // Hold counter and timeout pulse register.
    always_ff @(posedge ClockIn or negedge ResetInN) begin
        if (!ResetInN) begin
            r_hold    <= {HOLD_CNT_W{1'b0}};
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= w_hold_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    assign TimeoutEvent = r_timeout;
`else
    assign TimeoutEvent = 1'b0;
`endif

    assign Grant0          = r_grant0;
    assign Grant1          = r_grant1;
    assign Select          = r_select;
    assign MemAccessEnable = r_mae;
    assign Busy            = r_busy;

endmodule

// File: tb/tb_sme_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sme_memory_arbiter
// Self-checking bench for sme_memory_arbiter (TURNAROUND_CYCLES=1,
// PRIORITY_RR=1, MAX_HOLD=4). Table-driven vectors from reset, hand-written
// sequences for async reset and hold/timeout behaviour, then randomized
// requests checked against an ownership-level reference model.
// Honours SME_ARB_TIMEOUT_EN when defined for the build.
// Output vector order in all checks: {Grant0, Grant1, Select, MAE, Busy, TO}.
// -----------------------------------------------------------------------------
module tb_sme_memory_arbiter;

    localparam int T  = 1;
    localparam bit RR = 1'b1;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic req0;
    logic req1;
    logic grant0, grant1, sel, mae, busy, tmo;

    int n_cmp = 0;
    int n_bad = 0;

    sme_memory_arbiter #(
        .TURNAROUND_CYCLES (T),
        .PRIORITY_RR       (RR),
        .MAX_HOLD          (MH)
    ) dut (
        .ClockIn         (clk),
        .ResetInN        (rst_n),
        .Req0            (req0),
        .Req1            (req1),
        .Grant0          (grant0),
        .Grant1          (grant1),
        .Select          (sel),
        .MemAccessEnable (mae),
        .Busy            (busy),
        .TimeoutEvent    (tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [5:0] dut_vec();
        return {grant0, grant1, sel, mae, busy, tmo};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (g0 g1 sel mae busy to)", name, act, exp);
        end
    endtask

    // Reference model: who owns the memory, who is waiting out a gap, where
    // the mux points, and how long the current owner has kept someone waiting.
    int   m_owner;   // -1 = nobody
    int   m_pend;    // -1 = no pending winner
    int   m_wait;    // edges left before the pending winner is granted
    int   m_sel;
    int   m_last;
    int   m_hold;
    logic m_to;

    task automatic model_reset();
        m_owner = -1; m_pend = -1; m_wait = 0;
        m_sel = 0; m_last = 1; m_hold = 0; m_to = 1'b0;
    endtask

    task automatic model_take(input int t);
        m_owner = t; m_last = t; m_hold = 0; m_pend = -1;
    endtask

    task automatic model_move(input int t);
        if (t == m_sel || T == 0) begin
            m_sel = t;
            model_take(t);
        end else begin
            m_sel = t; m_pend = t; m_wait = T; m_hold = 0;
        end
    endtask

    task automatic model_step(input logic r0, input logic r1);
        bit rq [2];
        rq[0] = r0;
        rq[1] = r1;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            int own = m_owner;
            if (!rq[own]) begin
                m_owner = -1;
                if (rq[1-own]) model_move(1 - own);
            end else begin
`ifdef SME_ARB_TIMEOUT_EN
                if (rq[1-own]) begin
                    m_hold++;
                    if (m_hold == MH) begin
                        m_owner = -1;
                        m_to = 1'b1;
                        model_move(1 - own);
                    end
                end
`endif
            end
        end else if (m_pend >= 0) begin
            int p = m_pend;
            if (!rq[p]) begin
                m_pend = -1;
                if (rq[1-p]) model_move(1 - p);
            end else begin
                m_wait--;
                if (m_wait <= 0) model_take(p);
            end
        end else if (r0 || r1) begin
            int w;
            if (r0 && r1) w = RR ? (1 - m_last) : 0;
            else          w = r1 ? 1 : 0;
            model_move(w);
        end
    endtask

    function automatic logic [5:0] model_vec();
        logic s;
        s = (m_sel != 0);
        return {m_owner == 0, m_owner == 1, s, m_owner >= 0,
                (m_owner >= 0) || (m_pend >= 0), m_to};
    endfunction

    task automatic set_vec(input int i, input logic r0, input logic r1, input logic [5:0] e);
        tbl[i].r0 = r0; tbl[i].r1 = r1; tbl[i].exp = e;
    endtask

    task automatic cycle(input logic r0, input logic r1);
        req0 = r0;
        req1 = r1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Expected values for T=1, round-robin, starting from reset.
        set_vec( 0, 1'b1, 1'b0, 6'b100110); // Req0 alone: direct grant
        set_vec( 1, 1'b1, 1'b0, 6'b100110);
        set_vec( 2, 1'b0, 1'b0, 6'b000000);
        set_vec( 3, 1'b0, 1'b1, 6'b001010); // Select moves, gap
        set_vec( 4, 1'b0, 1'b1, 6'b011110); // Grant1 after turnaround
        set_vec( 5, 1'b0, 1'b0, 6'b001000); // Select retained in IDLE
        set_vec( 6, 1'b1, 1'b1, 6'b000010); // tie, last=1 -> requester 0
        set_vec( 7, 1'b1, 1'b1, 6'b100110);
        set_vec( 8, 1'b0, 1'b1, 6'b001010); // release, switch to waiter
        set_vec( 9, 1'b0, 1'b1, 6'b011110);
        set_vec(10, 1'b1, 1'b0, 6'b000010);
        set_vec(11, 1'b0, 1'b0, 6'b000000); // abort in SWITCH, no grant
        set_vec(12, 1'b0, 1'b1, 6'b001010);
        set_vec(13, 1'b1, 1'b0, 6'b000010); // abort with re-arbitration
        set_vec(14, 1'b1, 1'b0, 6'b100110);
        set_vec(15, 1'b0, 1'b0, 6'b000000);
        set_vec(16, 1'b1, 1'b1, 6'b001010); // tie, last=0 -> requester 1
        set_vec(17, 1'b1, 1'b1, 6'b011110);

        req0 = 1'b0;
        req1 = 1'b0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", dut_vec(), 6'b000000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", dut_vec(), 6'b000000);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].r0, tbl[i].r1);
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Async reset while requester 1 owns the memory: no clock edge needed.
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_in_grant1", dut_vec(), 6'b000000);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Hold behaviour while the other requester waits.
        cycle(1'b1, 1'b0);
        check("hold_grant0", dut_vec(), 6'b100110);
`ifdef SME_ARB_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 1'b1);
            check($sformatf("hold_wait%0d", k), dut_vec(), 6'b100110);
        end
        cycle(1'b1, 1'b1);
        check("timeout_pulse", dut_vec(), 6'b001011);
        cycle(1'b1, 1'b1);
        check("timeout_grant1", dut_vec(), 6'b011110);
        cycle(1'b1, 1'b0);
        check("reserve_switch", dut_vec(), 6'b000010);
        cycle(1'b1, 1'b0);
        check("reserve_grant0", dut_vec(), 6'b100110);
`else
        for (int k = 1; k <= 70; k++) begin
            cycle(1'b1, 1'b1);
            check($sformatf("no_preempt%0d", k), dut_vec(), 6'b100110);
        end
        cycle(1'b0, 1'b1);
        check("late_switch", dut_vec(), 6'b001010);
        cycle(1'b0, 1'b1);
        check("late_grant1", dut_vec(), 6'b011110);
`endif

        // Randomized requests against the reference model.
        do_reset();
        model_reset();
        begin
            logic r0, r1;
            r0 = 1'b0;
            r1 = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 3) == 0) r0 = ~r0;
                if ($urandom_range(0, 3) == 0) r1 = ~r1;
                req0 = r0;
                req1 = r1;
                @(posedge clk);
                model_step(r0, r1);
                #1;
                check($sformatf("rand%0d", n), dut_vec(), model_vec());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
